// File: rtl/chacha_round_engine.sv
// ChaCha round engine: one column or diagonal round per clock, optional feed-forward.
module chacha_round_engine #(
  parameter int unsigned ROUNDS   = 20,
  parameter bit          FEED_FWD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] state_in,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] state_out,
  output logic         busy
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = 16;
  localparam int unsigned STATE_W = WORD_W * NWORDS;
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] orig_q, orig_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WORD_W-1:0]  w [NWORDS];
  logic [WORD_W-1:0]  r [NWORDS];
  logic [STATE_W-1:0] rnd_flat;
  logic [STATE_W-1:0] fin_flat;

  // Quarter round; result packed as {d, c, b, a}
  function automatic logic [4*WORD_W-1:0] qr(input logic [WORD_W-1:0] a_i,
                                             input logic [WORD_W-1:0] b_i,
                                             input logic [WORD_W-1:0] c_i,
                                             input logic [WORD_W-1:0] d_i);
    logic [WORD_W-1:0] a, b, c, d;
    a = a_i;
    b = b_i;
    c = c_i;
    d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  // Word view of the working state, flattened round result and feed-forward sum
  for (genvar g = 0; g < NWORDS; g++) begin : g_words
    assign w[g] = work_q[WORD_W*g +: WORD_W];
    assign rnd_flat[WORD_W*g +: WORD_W] = r[g];
    assign fin_flat[WORD_W*g +: WORD_W] =
      FEED_FWD ? r[g] + orig_q[WORD_W*g +: WORD_W] : r[g];
  end

  // One round: column on even counter, diagonal on odd
  always_comb begin
    r = w;
    if (!cnt_q[0]) begin
      {r[12], r[8],  r[4], r[0]} = qr(w[0], w[4], w[8],  w[12]);
      {r[13], r[9],  r[5], r[1]} = qr(w[1], w[5], w[9],  w[13]);
      {r[14], r[10], r[6], r[2]} = qr(w[2], w[6], w[10], w[14]);
      {r[15], r[11], r[7], r[3]} = qr(w[3], w[7], w[11], w[15]);
    end else begin
      {r[15], r[10], r[5], r[0]} = qr(w[0], w[5], w[10], w[15]);
      {r[12], r[11], r[6], r[1]} = qr(w[1], w[6], w[11], w[12]);
      {r[13], r[8],  r[7], r[2]} = qr(w[2], w[7], w[8],  w[13]);
      {r[14], r[9],  r[4], r[3]} = qr(w[3], w[4], w[9],  w[14]);
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    orig_d  = orig_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        out_d = '0;
        if (in_valid) begin
          work_d  = state_in;
          orig_d  = state_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else begin
          work_d = rnd_flat;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_RND) begin
            state_d = ST_DONE;
            out_d   = fin_flat;
          end
        end
      end
      ST_DONE: begin
        if (abort || out_ready) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      orig_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      orig_q      <= orig_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_chacha_round_engine.sv
// Self-checking bench for chacha_round_engine against a table-driven ChaCha model.
module tb_chacha_round_engine;

  localparam int NI = 4;
  localparam int RND [NI] = '{20, 8, 12, 20};
  localparam bit FFW [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;
  logic [511:0] state_in = '0;
  logic         in_ready_v  [NI];
  logic         out_valid_v [NI];
  logic         busy_v      [NI];
  logic [511:0] state_out_v [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chacha_round_engine #(.ROUNDS(20), .FEED_FWD(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .state_in(state_in), .abort(abort), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .state_out(state_out_v[0]), .busy(busy_v[0]));
  chacha_round_engine #(.ROUNDS(8), .FEED_FWD(1'b1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .state_in(state_in), .abort(abort), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .state_out(state_out_v[1]), .busy(busy_v[1]));
  chacha_round_engine #(.ROUNDS(12), .FEED_FWD(1'b0)) u_r12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .state_in(state_in), .abort(abort), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .state_out(state_out_v[2]), .busy(busy_v[2]));
  chacha_round_engine #(.ROUNDS(20), .FEED_FWD(1'b0)) u_r20n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .state_in(state_in), .abort(abort), .out_valid(out_valid_v[3]),
    .out_ready(out_ready), .state_out(state_out_v[3]), .busy(busy_v[3]));

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rol(input int unsigned v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference ChaCha block: rounds alternate between column and diagonal groups
  function automatic logic [511:0] ref_block(input logic [511:0] s, input int rounds, input bit ff);
    int unsigned x [16];
    int unsigned o [16];
    logic [511:0] res;
    int grp [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                       '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    for (int i = 0; i < 16; i++) begin
      x[i] = s[32*i +: 32];
      o[i] = x[i];
    end
    for (int rr = 0; rr < rounds; rr++) begin
      for (int q = 0; q < 4; q++) begin
        int a, b, c, d;
        a = grp[(rr % 2) * 4 + q][0];
        b = grp[(rr % 2) * 4 + q][1];
        c = grp[(rr % 2) * 4 + q][2];
        d = grp[(rr % 2) * 4 + q][3];
        x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = ff ? x[i] + o[i] : x[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic bit all_idle();
    bit ok = 1'b1;
    for (int i = 0; i < NI; i++) if (!in_ready_v[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_all_idle();
    int n = 0;
    while (!all_idle() && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 512'(all_idle()), 512'(1));
  endtask

  // Push one block into every instance and check latency and result of each
  task automatic run_block(input string tag, input logic [511:0] s, output logic [511:0] main_res);
    int lat [NI];
    logic [511:0] res [NI];
    wait_all_idle();
    out_ready = 1'b1;
    state_in  = s;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1;
      res[i] = '0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("%s_zero_out", tag), state_out_v[0], '0);
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && out_valid_v[i]) begin
          lat[i] = k;
          res[i] = state_out_v[i];
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_lat%0d", tag, i), 512'(lat[i]), 512'(RND[i]));
      check($sformatf("%s_res%0d", tag, i), res[i], ref_block(s, RND[i], FFW[i]));
    end
    main_res = res[0];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] s, mres, exp;
    int unsigned rfc [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    bit seen;
    int k, got, prev, cyc;
    logic [511:0] exp_q [$];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 512'(out_valid_v[0]), 512'(0));
    check("rst_busy", 512'(busy_v[0]), 512'(0));
    check("rst_state_out", state_out_v[0], '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 512'(in_ready_v[0]), 512'(1));

    // Known-answer vector accepted on the first edge after release
    for (int i = 0; i < 16; i++) s[32*i +: 32] = rfc[i];
    run_block("rfc", s, mres);
    check("rfc_w0", 512'(mres[31:0]), 512'(32'he4e7f110));
    check("rfc_w1", 512'(mres[63:32]), 512'(32'h15593bd1));
    check("rfc_w15", 512'(mres[511:480]), 512'(32'h4e3c50a2));

    // All-zero state stays zero for every variant
    run_block("zero", '0, mres);
    check("zero_main", mres, '0);

    // Random blocks
    for (int t = 0; t < 4; t++) run_block($sformatf("rnd%0d", t), rand_state(), mres);

    // Backpressure in DONE
    wait_all_idle();
    s = rand_state();
    exp = ref_block(s, 20, 1'b1);
    out_ready = 1'b0;
    state_in = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid_v[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_lat", 512'(k), 512'(20));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", 512'(out_valid_v[0]), 512'(1));
      check("bp_data", state_out_v[0], exp);
      check("bp_in_ready", 512'(in_ready_v[0]), 512'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", 512'(out_valid_v[0]), 512'(0));
    check("bp_rel_in_ready", 512'(in_ready_v[0]), 512'(1));
    check("bp_rel_data", state_out_v[0], '0);

    // Abort after seven rounds
    wait_all_idle();
    state_in = rand_state();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (out_valid_v[i]) seen = 1'b1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < NI; i++) if (out_valid_v[i]) seen = 1'b1;
    check("abort_no_valid", 512'(seen), 512'(0));
    check("abort_busy", 512'(busy_v[0]), 512'(0));
    check("abort_all_idle", 512'(all_idle()), 512'(1));
    // Abort while idle must not block acceptance
    abort = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_accept", 512'(busy_v[0]), 512'(1));
    wait_all_idle();
    run_block("post_abort", rand_state(), mres);

    // Reset mid-run
    wait_all_idle();
    state_in = rand_state();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 512'(busy_v[0]), 512'(0));
    check("mrst_valid", 512'(out_valid_v[0]), 512'(0));
    check("mrst_data", state_out_v[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_in_ready", 512'(in_ready_v[0]), 512'(1));
    run_block("post_rst", rand_state(), mres);

    // Back-to-back stream on the main instance
    wait_all_idle();
    out_ready = 1'b1;
    in_valid = 1'b1;
    got = 0;
    prev = -1;
    cyc = 0;
    while (got < 5 && cyc < 300) begin
      if (out_valid_v[0]) begin
        if (exp_q.size() > 0) check("b2b_data", state_out_v[0], exp_q.pop_front());
        else check("b2b_underflow", 512'(1), 512'(0));
        if (prev >= 0) check("b2b_period", 512'(cyc - prev), 512'(22));
        prev = cyc;
        got++;
      end
      if (in_ready_v[0]) begin
        s = rand_state();
        state_in = s;
        exp_q.push_back(ref_block(s, 20, 1'b1));
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_count", 512'(got), 512'(5));
    in_valid = 1'b0;
    wait_all_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chacha_round_engine.md
CHACHA_ROUND_ENGINE -- requirements
Module: chacha_round_engine

Interface
REQ-001 Parameter ROUNDS, default 20: number of ChaCha rounds applied; SHALL be even and in 2..32 (8, 12 and 20 are the supported values).
REQ-002 Parameter FEED_FWD, default 1: 1 = output is permuted state plus input state (word-wise mod 2^32); 0 = raw permuted state.
REQ-003 Reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  clock, all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  state_in is valid.
REQ-007 in_ready  output  1  engine can accept a block.
REQ-008 state_in  input  512  16-word input state; word i = state_in[32*i+31:32*i].
REQ-009 abort  input  1  synchronous cancel of the block in flight.
REQ-010 out_valid  output  1  state_out is valid.
REQ-011 out_ready  input  1  consumer accepts state_out.
REQ-012 state_out  output  512  16-word result, same word ordering as state_in.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 QR(a,b,c,d), all arithmetic mod 2^32: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
REQ-015 Column round: QR on words (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15), all four in parallel within one cycle.
REQ-016 Diagonal round: QR on words (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14), all four in parallel within one cycle.
REQ-017 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy = (RUN or DONE).
REQ-019 IDLE: on in_valid=1, latch state_in into the working and original registers, clear the 5-bit round counter, go to RUN; otherwise stay.
REQ-020 RUN: each cycle applies one round to the working state; column round when the counter is even, diagonal round when odd; the counter then increments.
REQ-021 RUN exits to DONE on the edge that applies round ROUNDS (counter = ROUNDS-1); out_valid rises exactly ROUNDS clock edges after the accepting edge.
REQ-022 DONE: state_out = working + original when FEED_FWD=1, else working; value held stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1: transfer completes; go to IDLE on that edge; in_ready is 0 during that cycle, so the next block is accepted no earlier than the following cycle.
REQ-024 abort=1 in RUN or DONE: go to IDLE on the next edge with no output transfer; abort has priority over out_ready; abort in IDLE is ignored and does not block acceptance.
REQ-025 state_in and in_valid are ignored outside IDLE; the original register never changes outside acceptance.
REQ-026 state_out SHALL read 0 whenever out_valid=0.

Reset
REQ-027 rst_n low at any time, including mid-RUN, forces IDLE, round counter 0, working and original registers 0, out_valid 0, busy 0, in_ready 1 (after release), state_out 0.
REQ-028 First acceptance is possible on the first rising edge with rst_n high.

Verification
REQ-029 RFC 8439 2.3.2 input (61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000), ROUNDS=20, FEED_FWD=1 -> out_valid after 20 edges; word0 = e4e7f110, word1 = 15593bd1, word15 = 4e3c50a2.
REQ-030 All-zero state_in, both FEED_FWD values -> all-zero state_out; out_valid rises exactly ROUNDS edges after acceptance, checked for ROUNDS = 8, 12 and 20.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out stable, in_ready stays 0; raise out_ready -> IDLE next edge.
REQ-032 Assert abort at round 7 -> IDLE next edge, no out_valid pulse; next block gives the correct result.
REQ-033 Drop rst_n mid-RUN (round 5) -> outputs 0 immediately; after release, in_ready=1 and a new block completes correctly.
REQ-034 Back-to-back stream, in_valid and out_ready held at 1 -> one block per ROUNDS+2 cycles; results match the reference model in order.
